// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle adder/subtractor that processes CHUNK bits
// per clock, passing the carry between chunks through a register. A start
// request is accepted while not busy. done pulses for one cycle when
// sum/cout/overflow are valid, and they hold until the next accepted start.
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // The index is at least one bit wide so that the single-chunk case still
  // has a legal counter. Chunk slots are padded to a power of two so that the
  // index width exactly matches the mux depth.
  localparam int IW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NSLOT = 1 << IW;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] xa_reg;
  logic [WIDTH-1:0] yb_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [CHUNK-1:0] xa_ch [NSLOT];
  logic [CHUNK-1:0] yb_ch [NSLOT];
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;

  // Split the latched operands into chunk slots. Only the chunk selected by
  // the index is replaced in the next sum. Any padding slots read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NCHUNK) begin : g_live
        assign xa_ch[gi] = xa_reg[gi*CHUNK +: CHUNK];
        assign yb_ch[gi] = yb_reg[gi*CHUNK +: CHUNK];
        assign sum_next[gi*CHUNK +: CHUNK] =
          (idx_reg == IW'(gi)) ? chunk_sum[CHUNK-1:0] : sum_reg[gi*CHUNK +: CHUNK];
      end else begin : g_pad
        assign xa_ch[gi] = '0;
        assign yb_ch[gi] = '0;
      end
    end
  endgenerate

  // Datapath for the current chunk. This is a CHUNK-bit add plus the
  // registered carry.
  assign chunk_sum  = {1'b0, xa_ch[idx_reg]} + {1'b0, yb_ch[idx_reg]}
                    + {{CHUNK{1'b0}}, carry_reg};
  assign last_chunk = (idx_reg == IW'(NCHUNK - 1));

  // Control FSM and all state. In IDLE and DONE a start request is accepted.
  // In BUSY the FSM walks through the chunks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      xa_reg    <= '0;
      yb_reg    <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            // Subtraction is x + ~y + 1. The +1 comes in through the carry.
            xa_reg    <= x;
            yb_reg    <= y ^ {WIDTH{sub}};
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= BUSY;
          end else begin
            state_reg <= IDLE;
          end
        end
        BUSY: begin
          sum_reg   <= sum_next;
          carry_reg <= chunk_sum[CHUNK];
          if (last_chunk) begin
            cout_reg  <= chunk_sum[CHUNK];
            ovf_reg   <= (xa_reg[WIDTH-1] == yb_reg[WIDTH-1]) &&
                         (chunk_sum[CHUNK-1] != xa_reg[WIDTH-1]);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Testbench for chunked_serial_adder. The directed scenarios run on an 8/2
// instance. Random operations run on the 8/2, 8/8, 16/4 and 32/1
// configurations at the same time. Expected results are pushed to per-instance
// queues when an operation is started, and they are popped on each done pulse.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start_m;
  logic        start_r;
  logic        sub_t;
  logic        cin_t;
  logic [31:0] x_t;
  logic [31:0] y_t;

  logic        busy0, done0, cout0, ovf0;
  logic [7:0]  sum0;
  logic        busy1, done1, cout1, ovf1;
  logic [7:0]  sum1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] sum2;
  logic        busy3, done3, cout3, ovf3;
  logic [31:0] sum3;

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$], q1[$], q2[$], q3[$];
  exp_t e0, e1, e2, e3;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .reset(reset), .start(start_m), .sub(sub_t), .x(x_t[7:0]), .y(y_t[7:0]),
    .cin(cin_t), .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .overflow(ovf0));

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_w8c8 (
    .clk(clk), .reset(reset), .start(start_r), .sub(sub_t), .x(x_t[7:0]), .y(y_t[7:0]),
    .cin(cin_t), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut_w16c4 (
    .clk(clk), .reset(reset), .start(start_r), .sub(sub_t), .x(x_t[15:0]), .y(y_t[15:0]),
    .cin(cin_t), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2));

  chunked_serial_adder #(.WIDTH(32), .CHUNK(1)) dut_w32c1 (
    .clk(clk), .reset(reset), .start(start_r), .sub(sub_t), .x(x_t), .y(y_t),
    .cin(cin_t), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .overflow(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
    exp_t r;
    r.sum  = s;
    r.cout = c;
    r.ovf  = o;
    return r;
  endfunction

  // Reference result: a flat w-bit add of x and (y or ~y) plus the carry-in,
  // with signed overflow taken from the operand and result sign bits.
  function automatic exp_t model(input int w, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci);
    logic [63:0] mask, a64, b64, full;
    exp_t r;
    mask   = (64'd1 << w) - 64'd1;
    a64    = {32'd0, a} & mask;
    b64    = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    full   = a64 + b64 + (s ? 64'd1 : {63'd0, ci});
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (a64[w-1] == b64[w-1]) && (full[w-1] != a64[w-1]);
    return r;
  endfunction

  // Result monitors: each done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL w8c2_result: got unexpected done sum=%h, required no done", sum0);
      end else begin
        e0 = q0.pop_front();
        $display("[TB] w8c2 done sum=%h cout=%b ovf=%b", sum0, cout0, ovf0);
        if ({cout0, sum0, ovf0} !== {e0.cout, e0.sum[7:0], e0.ovf}) begin
          fails++;
          $display("FAIL w8c2_result: got cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                   cout0, sum0, ovf0, e0.cout, e0.sum[7:0], e0.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL w8c8_result: got unexpected done sum=%h, required no done", sum1);
      end else begin
        e1 = q1.pop_front();
        $display("[TB] w8c8 done sum=%h cout=%b ovf=%b", sum1, cout1, ovf1);
        if ({cout1, sum1, ovf1} !== {e1.cout, e1.sum[7:0], e1.ovf}) begin
          fails++;
          $display("FAIL w8c8_result: got cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                   cout1, sum1, ovf1, e1.cout, e1.sum[7:0], e1.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL w16c4_result: got unexpected done sum=%h, required no done", sum2);
      end else begin
        e2 = q2.pop_front();
        $display("[TB] w16c4 done sum=%h cout=%b ovf=%b", sum2, cout2, ovf2);
        if ({cout2, sum2, ovf2} !== {e2.cout, e2.sum[15:0], e2.ovf}) begin
          fails++;
          $display("FAIL w16c4_result: got cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                   cout2, sum2, ovf2, e2.cout, e2.sum[15:0], e2.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL w32c1_result: got unexpected done sum=%h, required no done", sum3);
      end else begin
        e3 = q3.pop_front();
        $display("[TB] w32c1 done sum=%h cout=%b ovf=%b", sum3, cout3, ovf3);
        if ({cout3, sum3, ovf3} !== {e3.cout, e3.sum, e3.ovf}) begin
          fails++;
          $display("FAIL w32c1_result: got cout=%b sum=%h ovf=%b, required cout=%b sum=%h ovf=%b",
                   cout3, sum3, ovf3, e3.cout, e3.sum, e3.ovf);
        end
      end
    end
  end

  // Drive one operation into the 8/2 instance. Scramble the inputs after the
  // accepting edge, and report how many edges passed until done (-1 if done
  // never came).
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, output int lat);
    sub_t = s; x_t = a; y_t = b; cin_t = ci; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    x_t = $urandom; y_t = $urandom; cin_t = 1'($urandom); sub_t = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done0) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all zero",
               busy0, done0, sum0, cout0, ovf0);
    end
    tests++;
    if ({busy1, busy2, busy3, done1, done2, done3} !== 6'b0) begin
      fails++;
      $display("FAIL reset_others: got busy=%b%b%b done=%b%b%b, required all zero",
               busy1, busy2, busy3, done1, done2, done3);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    q0.push_back(mk(32'h04, 1'b0, 1'b0));
    run_op(1'b0, 32'h01, 32'h03, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL add_latency: got %0d edges, required 4", lat);
    end
    @(posedge clk); #1;
    tests++;
    if (done0 !== 1'b0) begin
      fails++;
      $display("FAIL add_done_width: got done=%b one edge later, required 0", done0);
    end
    tests++;
    if (sum0 !== 8'h04) begin
      fails++;
      $display("FAIL add_sum_hold: got sum=%h after done, required 04", sum0);
    end
  endtask

  task automatic test_carry();
    int lat;
    q0.push_back(mk(32'h00, 1'b1, 1'b0));
    run_op(1'b0, 32'hFF, 32'h01, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL carry_latency: got %0d edges, required 4", lat);
    end
    q0.push_back(mk(32'h80, 1'b0, 1'b1));
    run_op(1'b0, 32'h7F, 32'h00, 1'b1, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL cin_ovf_latency: got %0d edges, required 4", lat);
    end
  endtask

  task automatic test_sub();
    int lat;
    q0.push_back(mk(32'hFE, 1'b0, 1'b0));
    run_op(1'b1, 32'h05, 32'h07, 1'b1, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL sub_latency: got %0d edges, required 4", lat);
    end
    q0.push_back(mk(32'h7F, 1'b1, 1'b1));
    run_op(1'b1, 32'h80, 32'h01, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL sub_ovf_latency: got %0d edges, required 4", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    q0.push_back(mk(32'h30, 1'b0, 1'b0));
    sub_t = 1'b0; x_t = 32'h10; y_t = 32'h20; cin_t = 1'b0; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    @(posedge clk); #1;
    // A second request while busy must be dropped. Its operands must not leak
    // into the result.
    x_t = 32'hAA; y_t = 32'h55; cin_t = 1'b1; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0; x_t = 32'h00;
    tests++;
    if ({busy0, done0} !== 2'b10) begin
      fails++;
      $display("FAIL busy_ignore: got busy=%b done=%b at edge 2, required busy=1 done=0", busy0, done0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy0, done0} !== 2'b01) begin
      fails++;
      $display("FAIL busy_first_done: got busy=%b done=%b at edge 4, required busy=0 done=1", busy0, done0);
    end
    q0.push_back(mk(32'h20, 1'b1, 1'b0));
    sub_t = 1'b1; x_t = 32'h30; y_t = 32'h10; start_m = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start_m = 1'b0;
      if (done0) begin
        lat = n;
        break;
      end
    end
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL back_to_back_spacing: got %0d edges between dones, required 5", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    sub_t = 1'b0; x_t = 32'h55; y_t = 32'h22; cin_t = 1'b0; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
      fails++;
      $display("FAIL abort_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all zero",
               busy0, done0, sum0, cout0, ovf0);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done0 || busy0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: got activity=%b after reset, required 0", seen);
    end
    q0.push_back(mk(32'h77, 1'b0, 1'b0));
    run_op(1'b0, 32'h55, 32'h22, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL abort_restart_latency: got %0d edges, required 4", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s, ci;
    bit          ok;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom;
      s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      q0.push_back(model(8, s, a, b, ci));
      q1.push_back(model(8, s, a, b, ci));
      q2.push_back(model(16, s, a, b, ci));
      q3.push_back(model(32, s, a, b, ci));
      sub_t = s; x_t = a; y_t = b; cin_t = ci;
      start_m = 1'b1; start_r = 1'b1;
      @(posedge clk); #1;
      start_m = 1'b0; start_r = 1'b0;
      x_t = $urandom; y_t = $urandom;
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        if (!busy0 && !busy1 && !busy2 && !busy3) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL random_timeout: op %0d still busy after 60 edges, required idle", i);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ((q0.size() + q1.size() + q2.size() + q3.size()) !== 0) begin
      fails++;
      $display("FAIL random_drain: got %0d/%0d/%0d/%0d results outstanding, required 0",
               q0.size(), q1.size(), q2.size(), q3.size());
    end
  endtask

  initial begin
    start_m = 1'b0; start_r = 1'b0; sub_t = 1'b0; cin_t = 1'b0;
    x_t = '0; y_t = '0; reset = 1'b1;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
